// File: rtl/score_pkg.sv
// Shared types and constants for the score entry and score readout paths.
package score_pkg;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for an already-synchronised level; a held level yields one event.
// Zero latency (event is combinational from the current level and last cycle's copy).
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/score_entry.sv
// Keyed BCD digit entry with serial BCD-to-binary conversion; commit event in cycle t gives
// value_valid from t+1+NUM_DIGITS, held with value_out until value_ready or a clear abort.
module score_entry
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int WIDTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIGIT_W-1:0]            digit_in,
  input  logic                          digit_push,
  input  logic                          commit,
  input  logic                          clear,
  input  logic                          value_ready,
  output logic [WIDTH-1:0]              value_out,
  output logic                          value_valid,
  output logic [DIGIT_W*NUM_DIGITS-1:0] entered_bcd,
  output logic [2:0]                    digit_count,
  output logic                          busy,
  output logic                          err
);

  localparam int BCD_W = DIGIT_W * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic ev_push, ev_commit, ev_clear;

  rise_detect u_push   (.clk(clk), .rst_n(rst_n), .sig_i(digit_push), .rise_o(ev_push));
  rise_detect u_commit (.clk(clk), .rst_n(rst_n), .sig_i(commit),     .rise_o(ev_commit));
  rise_detect u_clear  (.clk(clk), .rst_n(rst_n), .sig_i(clear),      .rise_o(ev_clear));

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q,   bcd_d;
  logic [2:0]         cnt_q,   cnt_d;
  logic [WIDTH-1:0]   acc_q,   acc_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [WIDTH-1:0]   val_q,   val_d;
  logic               vld_q,   vld_d;
  logic               err_q,   err_d;

  logic [DIGIT_W-1:0] cur_digit;
  logic [WIDTH-1:0]   acc_mac;

  // acc*10 as two shifts; WIDTH is sized so the largest entry cannot overflow.
  assign cur_digit = bcd_q[DIGIT_W*idx_q +: DIGIT_W];
  assign acc_mac   = (acc_q << 3) + (acc_q << 1) + WIDTH'(cur_digit);

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    val_d   = val_q;
    vld_d   = vld_q;
    err_d   = 1'b0;

    case (state_q)
      ENTRY: begin
        if (ev_clear) begin
          bcd_d = '0;
          cnt_d = '0;
        end else if (ev_commit) begin
          acc_d   = '0;
          idx_d   = IDX_W'(NUM_DIGITS - 1);
          state_d = CONVERT;
        end else if (ev_push) begin
          if (digit_in <= BCD_MAX && cnt_q < 3'(NUM_DIGITS)) begin
            bcd_d = (bcd_q << DIGIT_W) | BCD_W'(digit_in);
            cnt_d = cnt_q + 3'd1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      CONVERT: begin
        if (ev_clear) begin
          bcd_d   = '0;
          cnt_d   = '0;
          vld_d   = 1'b0;
          state_d = ENTRY;
        end else begin
          acc_d = acc_mac;
          idx_d = idx_q - 1'b1;
          if (idx_q == '0) begin
            val_d   = acc_mac;
            vld_d   = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        // A clear wins over a same-cycle ready; value_out keeps its last value either way.
        if (ev_clear || (vld_q && value_ready)) begin
          bcd_d   = '0;
          cnt_d   = '0;
          vld_d   = 1'b0;
          state_d = ENTRY;
        end
      end

      default: state_d = ENTRY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ENTRY;
      bcd_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign value_out   = val_q;
  assign value_valid = vld_q;
  assign entered_bcd = bcd_q;
  assign digit_count = cnt_q;
  assign busy        = (state_q != ENTRY);
  assign err         = err_q;

endmodule

// File: tb/tb_score_entry.sv
// Bench for score_entry: table of entry vectors plus hand-written corner sequences.
module tb_score_entry;

  logic        clk;
  logic        rst_n;
  logic [3:0]  digit_in;
  logic        digit_push;
  logic        commit;
  logic        clear;
  logic        value_ready;
  logic [15:0] value_out;
  logic        value_valid;
  logic [15:0] entered_bcd;
  logic [2:0]  digit_count;
  logic        busy;
  logic        err;

  score_entry dut (
    .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .digit_push(digit_push),
    .commit(commit), .clear(clear), .value_ready(value_ready),
    .value_out(value_out), .value_valid(value_valid), .entered_bcd(entered_bcd),
    .digit_count(digit_count), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    int          n;
    logic [15:0] bcd;
    logic [15:0] val;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_digit(input logic [3:0] d, output logic e);
    digit_in   = d;
    digit_push = 1'b1;
    tick();
    e          = err;
    digit_push = 1'b0;
    tick();
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask

  // Raises commit and returns the number of ticks until value_valid is seen (0 = timeout).
  task automatic commit_and_wait(output int lat);
    lat    = 0;
    commit = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      commit = 1'b0;
      if (value_valid && lat == 0) lat = i;
      if (lat != 0) break;
    end
    if (lat == 0) begin
      bad++;
      total++;
      $display("FAIL valid_timeout: got no value_valid want within 20 cycles");
    end
  endtask

  // Scoreboard: every completed handshake must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && value_valid && value_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_handshake: got %0d want none", value_out);
      end else begin
        chk("value_out", 32'(value_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic e;
    int   lat;
    logic seen;

    rst_n = 1'b0; digit_in = '0; digit_push = 1'b0; commit = 1'b0;
    clear = 1'b0; value_ready = 1'b0;

    tbl[0] = '{4, 16'h1234, 16'd1234};
    tbl[1] = '{1, 16'h0007, 16'd7};
    tbl[2] = '{4, 16'h9999, 16'd9999};
    tbl[3] = '{0, 16'h0000, 16'd0};
    tbl[4] = '{4, 16'h0501, 16'd501};
    tbl[5] = '{2, 16'h0080, 16'd80};
    tbl[6] = '{3, 16'h0999, 16'd999};

    repeat (3) tick();
    chk("rst_value_out", 32'(value_out), 0);
    chk("rst_valid", 32'(value_valid), 0);
    chk("rst_bcd", 32'(entered_bcd), 0);
    chk("rst_count", 32'(digit_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    tick();

    value_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      vec_t v;
      v = tbl[k];
      for (int i = 0; i < v.n; i++) begin
        push_digit(v.bcd[4*(v.n-1-i) +: 4], e);
        chk("push_err", 32'(e), 0);
      end
      chk("tbl_bcd", 32'(entered_bcd), 32'(v.bcd));
      chk("tbl_count", 32'(digit_count), 32'(v.n));
      exp_q.push_back(v.val);
      commit_and_wait(lat);
      chk("tbl_latency", 32'(lat), 5);
      tick();
      chk("tbl_valid_drop", 32'(value_valid), 0);
      chk("tbl_count_clr", 32'(digit_count), 0);
      chk("tbl_bcd_clr", 32'(entered_bcd), 0);
      chk("tbl_busy", 32'(busy), 0);
      chk("tbl_sb_empty", 32'(exp_q.size()), 0);
    end

    // Overfull entry and non-BCD digit are rejected with a one-cycle err pulse.
    for (int i = 1; i <= 4; i++) push_digit(4'(i), e);
    push_digit(4'd5, e);
    chk("err_5th", 32'(e), 1);
    chk("err_5th_bcd", 32'(entered_bcd), 32'h1234);
    chk("err_5th_count", 32'(digit_count), 4);
    chk("err_one_cycle", 32'(err), 0);
    pulse_clear();
    chk("clear_bcd", 32'(entered_bcd), 0);
    push_digit(4'd3, e);
    push_digit(4'hB, e);
    chk("err_nonbcd", 32'(e), 1);
    chk("err_nonbcd_count", 32'(digit_count), 1);
    chk("err_nonbcd_bcd", 32'(entered_bcd), 32'h3);
    pulse_clear();

    // Backpressure: value held while ready is low; pushes in DONE are ignored.
    value_ready = 1'b0;
    push_digit(4'd4, e);
    push_digit(4'd2, e);
    exp_q.push_back(16'd42);
    commit_and_wait(lat);
    chk("bp_latency", 32'(lat), 5);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid_hold", 32'(value_valid), 1);
      chk("bp_value_hold", 32'(value_out), 42);
      tick();
    end
    push_digit(4'd5, e);
    chk("done_push_ignored", 32'(digit_count), 2);
    chk("done_push_no_err", 32'(e), 0);
    value_ready = 1'b1;
    tick();
    chk("bp_valid_drop", 32'(value_valid), 0);
    chk("bp_count_clr", 32'(digit_count), 0);
    chk("bp_value_kept", 32'(value_out), 42);
    chk("bp_sb_empty", 32'(exp_q.size()), 0);

    // Clear during CONVERT aborts without ever raising valid.
    push_digit(4'd3, e);
    push_digit(4'd3, e);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("abort_busy", 32'(busy), 1);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    seen  = value_valid;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | value_valid;
    end
    chk("abort_no_valid", 32'(seen), 0);
    chk("abort_busy_low", 32'(busy), 0);
    chk("abort_bcd", 32'(entered_bcd), 0);
    chk("abort_count", 32'(digit_count), 0);

    // Clear and push in the same cycle leave the entry empty.
    push_digit(4'd1, e);
    push_digit(4'd2, e);
    digit_in   = 4'd6;
    clear      = 1'b1;
    digit_push = 1'b1;
    tick();
    clear      = 1'b0;
    digit_push = 1'b0;
    chk("clrpush_bcd", 32'(entered_bcd), 0);
    chk("clrpush_count", 32'(digit_count), 0);
    chk("clrpush_err", 32'(err), 0);
    tick();

    // Held push enters exactly one digit.
    digit_in   = 4'd8;
    digit_push = 1'b1;
    repeat (20) tick();
    digit_push = 1'b0;
    tick();
    chk("hold_count", 32'(digit_count), 1);
    chk("hold_bcd", 32'(entered_bcd), 32'h8);

    // Reset while DONE clears everything.
    value_ready = 1'b0;
    commit_and_wait(lat);
    chk("rstdone_valid", 32'(value_valid), 1);
    rst_n = 1'b0;
    tick();
    chk("rstdone_value_out", 32'(value_out), 0);
    chk("rstdone_valid_low", 32'(value_valid), 0);
    chk("rstdone_bcd", 32'(entered_bcd), 0);
    chk("rstdone_count", 32'(digit_count), 0);
    chk("rstdone_busy", 32'(busy), 0);
    chk("rstdone_err", 32'(err), 0);
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
